// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush sequencing for the 5-stage RISC-V pipeline.
//
// Decides, every cycle, whether the PC, F/D, D/E and E/M registers hold or
// bubble. It handles load-use bubbles, branch-mispredict redirects with a
// multi-cycle F/D flush window, and whole-pipe freezes while data memory is
// busy. It also keeps saturating stall/mispredict counters and a sticky
// data-memory timeout flag.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   d_rs1, d_rs2              source register indices of the D instruction
//   d_use_rs1, d_use_rs2      D instruction actually reads rs1 / rs2
//   e_rd, e_mem_read          destination index / load flag of E instruction
//   e_br_valid                E holds a resolved conditional branch
//   e_br_taken, e_guess       actual and predicted branch outcome
//   dmem_busy                 data memory not ready this cycle
//   pc_stall, pc_redirect     hold PC / load PC from EX target
//   fd_stall, fd_flush        hold / bubble F/D
//   de_stall, de_flush        hold / bubble D/E
//   em_stall                  hold E/M
//   mem_timeout               sticky: dmem_busy held MEM_TIMEOUT cycles
//   stall_cnt, flush_cnt      saturating pc_stall-cycle / mispredict counters
//
// State table:
//   state | meaning
//   RUN   | normal issue; load-use bubbles allowed
//   FLUSH | post-redirect window, F/D and D/E bubbled, load-use ignored

module hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       d_rs1,
  input  logic [4:0]       d_rs2,
  input  logic             d_use_rs1,
  input  logic             d_use_rs2,
  input  logic [4:0]       e_rd,
  input  logic             e_mem_read,
  input  logic             e_br_valid,
  input  logic             e_br_taken,
  input  logic             e_guess,
  input  logic             dmem_busy,
  output logic             pc_stall,
  output logic             pc_redirect,
  output logic             fd_stall,
  output logic             fd_flush,
  output logic             de_stall,
  output logic             de_flush,
  output logic             em_stall,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // The mispredict cycle itself is the first flush cycle, so the FLUSH
  // state only has to cover the remaining FLUSH_CYCLES-1 cycles.
  localparam logic [3:0]  FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [16:0] TO_LIMIT     = 17'(MEM_TIMEOUT);

  state_t      state, state_nxt;
  logic [3:0]  fcnt, fcnt_nxt;
  logic [15:0] tcnt;
  logic [16:0] tcnt_inc;
  logic        mispredict;
  logic        loaduse;
  logic        rs1_hit;
  logic        rs2_hit;

  assign mispredict = e_br_valid & (e_br_taken != e_guess);
  assign rs1_hit    = d_use_rs1 & (d_rs1 == e_rd);
  assign rs2_hit    = d_use_rs2 & (d_rs2 == e_rd);
  assign loaduse    = e_mem_read & (e_rd != 5'd0) & (rs1_hit | rs2_hit);
  assign tcnt_inc   = {1'b0, tcnt} + 17'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      fcnt  <= 4'd0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    fcnt_nxt    = fcnt;
    pc_stall    = 1'b0;
    pc_redirect = 1'b0;
    fd_stall    = 1'b0;
    fd_flush    = 1'b0;
    de_stall    = 1'b0;
    de_flush    = 1'b0;
    em_stall    = 1'b0;
    if (!rst) begin
      if (dmem_busy) begin
        // Whole pipe frozen; a pending branch is re-evaluated once busy drops.
        pc_stall = 1'b1;
        fd_stall = 1'b1;
        de_stall = 1'b1;
        em_stall = 1'b1;
      end else if (mispredict) begin
        pc_redirect = 1'b1;
        fd_flush    = 1'b1;
        de_flush    = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_nxt = FLUSH;
          fcnt_nxt  = FLUSH_RELOAD;
        end else begin
          state_nxt = RUN;
          fcnt_nxt  = 4'd0;
        end
      end else if (state == FLUSH) begin
        fd_flush = 1'b1;
        de_flush = 1'b1;
        fcnt_nxt = fcnt - 4'd1;
        if (fcnt <= 4'd1) begin
          state_nxt = RUN;
        end
      end else if (loaduse) begin
        pc_stall = 1'b1;
        fd_stall = 1'b1;
        de_flush = 1'b1;
      end
    end
  end

  // Busy-run length counter; it parks at the limit so it can never wrap
  // back below the threshold during a very long busy period.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt        <= 16'd0;
      mem_timeout <= 1'b0;
    end else if (dmem_busy) begin
      if (tcnt_inc <= TO_LIMIT) begin
        tcnt <= tcnt_inc[15:0];
      end
      if (tcnt_inc >= TO_LIMIT) begin
        mem_timeout <= 1'b1;
      end
    end else begin
      tcnt <= 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (pc_redirect && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage RISC-V core.
- Generates the stall/flush controls for the PC register, the F/D register and the D/E register:
  - load-use bubbles;
  - branch-mispredict flushes, checking the EX branch outcome against the carried `guess` bit;
  - whole-pipe freezes while data memory is busy.
- Also keeps saturating performance counters and a sticky memory-timeout flag.

Parameters:
- FLUSH_CYCLES, 1, number of consecutive cycles F/D is flushed after a redirect (covers instruction-memory latency); legal 1..15.
- MEM_TIMEOUT, 255, consecutive dmem_busy cycles after which mem_timeout sets; legal 1..65535.
- CNT_W, 16, width of each performance counter.

Ports:
- clk in 1 clock
- rst in 1 synchronous active-high reset
- d_rs1 in 5 rs1 index of the instruction in D
- d_rs2 in 5 rs2 index of the instruction in D
- d_use_rs1 in 1 D instruction reads rs1
- d_use_rs2 in 1 D instruction reads rs2
- e_rd in 5 destination index of the instruction in E
- e_mem_read in 1 E instruction is a load
- e_br_valid in 1 E holds a resolved conditional branch
- e_br_taken in 1 actual branch outcome
- e_guess in 1 predicted outcome carried down the pipe
- dmem_busy in 1 data memory not ready this cycle
- pc_stall out 1 hold PC
- pc_redirect out 1 load PC from EX-computed target
- fd_stall out 1 hold F/D register
- fd_flush out 1 bubble F/D register
- de_stall out 1 hold D/E register
- de_flush out 1 bubble D/E register
- em_stall out 1 hold E/M register
- mem_timeout out 1 sticky error flag
- stall_cnt out CNT_W cycles with pc_stall=1
- flush_cnt out CNT_W mispredict events

Behaviour:
- Reset is synchronous; a reset applied mid-operation aborts any flush sequence. On reset:
  - state=RUN, flush counter=0, timeout counter=0;
  - mem_timeout=0, stall_cnt=0, flush_cnt=0.
- All stall/flush outputs are combinational from the current state and inputs (zero latency, Mealy). While rst=1, all stall/flush/redirect outputs are 0.
- Derived signals:
  - mispredict = e_br_valid & (e_br_taken != e_guess).
  - loaduse = e_mem_read & (e_rd != 0) & ((d_use_rs1 & d_rs1 == e_rd) | (d_use_rs2 & d_rs2 == e_rd)).
- Priority each cycle, highest first: dmem_busy > mispredict > FLUSH state > loaduse > normal.
- When dmem_busy=1:
  - pc_stall = fd_stall = de_stall = em_stall = 1; all flush outputs and pc_redirect are 0.
  - mispredict and loaduse are ignored; the branch stays in E and is re-evaluated when busy drops.
  - State and flush counter are frozen.
- When mispredict=1 (not busy):
  - pc_redirect=1, fd_flush=1, de_flush=1, pc_stall=0 for one cycle.
  - flush_cnt increments.
  - If FLUSH_CYCLES>1: state goes to FLUSH with counter = FLUSH_CYCLES-1; otherwise state stays RUN.
  - A mispredict arriving while in FLUSH restarts the counter and asserts pc_redirect again.
- In state FLUSH (not busy, no mispredict):
  - fd_flush=1, de_flush=1, all stalls 0.
  - Counter decrements; when it reaches 0 the state returns to RUN on the next edge.
  - loaduse is ignored in this state.
- When loaduse=1 in RUN:
  - pc_stall=1, fd_stall=1, de_flush=1.
  - No extra state; the hazard clears once the load advances.
- Normal: all outputs 0.
- Simultaneous stall and flush on one register never occurs.
- Timeout counter: increments on each consecutive dmem_busy cycle and clears when busy=0. On reaching MEM_TIMEOUT, mem_timeout sets and stays set until rst.
- stall_cnt and flush_cnt saturate at all-ones; they never wrap.

Test Plan:
- Reset: assert rst for 2 cycles with dmem_busy=1, e_br_valid=1 -> all outputs 0, counters 0, mem_timeout=0.
- Load-use: e_mem_read=1, e_rd=5, d_rs2=5, d_use_rs2=1 -> same cycle pc_stall=fd_stall=de_flush=1, stall_cnt 0->1. Repeat with e_rd=0 -> no stall.
- Mispredict with FLUSH_CYCLES=3: e_br_valid=1, taken=1, guess=0 for one cycle -> pc_redirect high 1 cycle; fd_flush/de_flush high 3 cycles; flush_cnt=1; correct prediction (taken=guess=1) -> no flush.
- Busy overrides: dmem_busy=1 plus mispredict for 4 cycles -> all four stalls high, no redirect; busy drops -> redirect on that cycle.
- Timeout with MEM_TIMEOUT=4: busy held 4 cycles -> mem_timeout=1 after the 4th edge; busy drops -> mem_timeout stays 1 until rst.
- Saturation with CNT_W=2: 5 load-use cycles -> stall_cnt stops at 3.
